usb_slave_line_state_monitor: RTL and testbench
===============================================

Name: usb_slave_line_state_monitor

Overview:
- Upstream stage of the slave RX status monitor.
- Watches the synchronised USB line state (D+/D-) and debounces SE0, J and K durations.
- Produces the connect state (disconnected / low-speed / full-speed) and a level resume-detect flag.
- The status monitor downstream converts those outputs into reset-event and resume-interrupt pulses.

Parameters:
- CONNECT_WAIT, 120: consecutive identical samples needed for connect or bus-reset detection (2.5 us at 48 MHz).
- RESUME_WAIT, 480: consecutive K samples needed to declare resume while connected (10 us at 48 MHz).
- CNT_W, 16: stability counter width; must hold max(CONNECT_WAIT, RESUME_WAIT).

Ports:
- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_bits  in  2  synchronised line state {D+, D-}: 00 SE0, 10 FS-J/LS-K, 01 FS-K/LS-J, 11 SE1.
- monitor_en  in  1  1 = monitoring active; 0 = freeze FSM and clear counter.
- connect_state  out  2  00 DISCONNECT, 01 LS_CONNECT, 10 FS_CONNECT; 11 never driven.
- resume_detected  out  1  level; 1 while a qualified resume K persists.
- line_state  out  2  registered copy of rx_bits (for debug/status).

Behaviour:
- Reset (rst_n low, asynchronous):
  - connect_state = 00, resume_detected = 0, line_state = 00, counter = 0.
  - Reset asserted mid-operation aborts any count immediately, with no glitch pulse.
  - Release is synchronous to clk.
- Sampling:
  - line_state <= rx_bits every edge.
  - cnt <= 1 when rx_bits != line_state; otherwise cnt <= cnt + 1, saturating at all-ones (no wrap).
- "Stable for N" means cnt == N at a clock edge. The state update is registered on that same edge, so the output changes N+1 edges after the first edge that sampled the new value.
- FSM states:
  - DISCONNECT:
    - line 10 stable CONNECT_WAIT -> FS_CONNECT.
    - line 01 stable CONNECT_WAIT -> LS_CONNECT.
    - SE0 and SE1 -> stay.
  - FS_CONNECT (J = 10, K = 01):
    - SE0 stable CONNECT_WAIT -> DISCONNECT (bus reset or detach), resume_detected <= 0.
    - K stable RESUME_WAIT -> resume_detected <= 1.
  - LS_CONNECT: same as FS_CONNECT with J = 01, K = 10.
- resume_detected:
  - Clears on the first edge where line_state is not K, or on any exit to DISCONNECT.
  - Never asserts in DISCONNECT.
- SE1 is noise: restarts the count and causes no transition in any state.
- Short glitches (duration < threshold) cause no state change; the counter restarts on every line change.
- Simultaneous events:
  - Only one threshold can match, since the line has a single value per edge.
  - SE0 qualification takes priority over any pending resume.
- Counter saturation: after saturating, the stable condition stays true and no further transitions retrigger. Each FSM transition fires once per stable interval.
- monitor_en = 0: cnt held at 0, connect_state and resume_detected hold their values, line_state keeps sampling. Re-enabling restarts counting from 1.
- connect_state changes at most once per CONNECT_WAIT interval. The downstream monitor relies on single-cycle changes to pulse its reset event.

Decomposition:
- Package usb_line_pkg:
  - Line-state encodings: SE0, FS_J, FS_K, SE1.
  - Connect-state encodings: DISCONNECT, LS_CONNECT, FS_CONNECT.
  - Default CONNECT_WAIT and RESUME_WAIT constants.
- Sub-module usb_line_stability_counter: line_state register plus saturating run-length counter; outputs line_state and cnt.
- The top level holds the FSM and resume logic.

Test Plan:
Test parameters: CONNECT_WAIT = 8, RESUME_WAIT = 16.
- Reset and FS attach: rst_n low, then rx_bits = 10 held -> connect_state 00 until the 9th edge after the first sample, then 10; resume_detected stays 0.
- LS attach with glitch: rx_bits = 01 for 5 cycles, 00 for 1, 01 held -> no connect at the first run; connect_state = 01 exactly 9 edges after the second run starts.
- Bus reset: in FS_CONNECT, SE0 for 7 cycles, then J -> stay 10. Then SE0 held -> connect_state 00 at the 9th edge.
- Resume: in FS_CONNECT, K = 01 held for 20 cycles -> resume_detected 1 from the 17th edge; line returns to 10 -> 0 the next edge. In LS_CONNECT, K = 10 gives the same result.
- SE1 and enable: in DISCONNECT, alternate 10/11 -> no connect. With monitor_en = 0 and J held for 50 cycles -> no change; re-enable -> connect 9 edges later.
- Async reset mid-count: assert rst_n during a 12-cycle K run in FS_CONNECT -> outputs 00/0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/usb_slave_line_state_monitor_pkg.sv
// Shared encodings and default timing constants for the USB slave line-state monitor.
package usb_line_pkg;

    // Line state as {D+, D-}. The FS names are used; LS swaps the meaning of J and K.
    typedef enum logic [1:0] {
        LINE_SE0  = 2'b00,
        LINE_FS_K = 2'b01,
        LINE_FS_J = 2'b10,
        LINE_SE1  = 2'b11
    } lineState_t;

    // Connect state as presented downstream; 2'b11 is never produced.
    typedef enum logic [1:0] {
        DISCONNECT = 2'b00,
        LS_CONNECT = 2'b01,
        FS_CONNECT = 2'b10
    } connectState_t;

    // 2.5 us and 10 us at 48 MHz.
    localparam int DEF_CONNECT_WAIT = 120;
    localparam int DEF_RESUME_WAIT  = 480;
    localparam int DEF_CNT_W        = 16;

    // Resume signalling is a K state, whose wire encoding depends on the connect speed.
    function automatic logic [1:0] kLineOf(input connectState_t speed);
        logic [1:0] kLine;
        kLine = (speed == LS_CONNECT) ? LINE_FS_J : LINE_FS_K;
        return kLine;
    endfunction

endpackage

// File: rtl/usb_slave_line_state_monitor_if.sv
// Line-side inputs and status outputs of the line-state monitor, grouped as one bundle.
interface usb_slave_line_state_monitor_if;
    import usb_line_pkg::*;

    logic [1:0] rx_bits;
    logic       monitor_en;
    logic [1:0] connect_state;
    logic       resume_detected;
    logic [1:0] line_state;

    // Driver side: supplies the synchronised line and the enable, observes status.
    modport master (
        output rx_bits,
        output monitor_en,
        input  connect_state,
        input  resume_detected,
        input  line_state
    );

    // Monitor side.
    modport slave (
        input  rx_bits,
        input  monitor_en,
        output connect_state,
        output resume_detected,
        output line_state
    );

endinterface

// File: rtl/usb_slave_line_state_monitor_counter.sv
// Registers the line state and counts how many consecutive edges it has kept the same value.
module usb_line_stability_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       rxBits,
    output logic [1:0]       lineState,
    output logic [CNT_W-1:0] cnt
);
    import usb_line_pkg::*;

    logic [1:0]       lineStateReg;
    logic [CNT_W-1:0] cntReg;

    // Sample the line every edge; restart the run on any change, saturate rather than wrap
    // so a long-held level can never re-hit a threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lineStateReg <= LINE_SE0;
            cntReg       <= '0;
        end else begin
            lineStateReg <= rxBits;
            if (!enable) begin
                cntReg <= '0;
            end else if (rxBits != lineStateReg) begin
                cntReg <= CNT_W'(1);
            end else if (cntReg != '1) begin
                cntReg <= cntReg + CNT_W'(1);
            end
        end
    end

    assign lineState = lineStateReg;
    assign cnt       = cntReg;

endmodule

// File: rtl/usb_slave_line_state_monitor.sv
// Debounces the USB line into a connect state and a level resume-detect flag.
module usb_slave_line_state_monitor #(
    parameter int CONNECT_WAIT = usb_line_pkg::DEF_CONNECT_WAIT,
    parameter int RESUME_WAIT  = usb_line_pkg::DEF_RESUME_WAIT,
    parameter int CNT_W        = usb_line_pkg::DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    usb_slave_line_state_monitor_if.slave bus
);
    import usb_line_pkg::*;

    logic [1:0]       lineState;
    logic [CNT_W-1:0] cnt;

    connectState_t stateReg;
    connectState_t stateNext;
    logic          resumeReg;
    logic          resumeNext;

    logic          connectStable;
    logic          resumeStable;
    logic [1:0]    kLine;

    usb_line_stability_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (bus.monitor_en),
        .rxBits    (bus.rx_bits),
        .lineState (lineState),
        .cnt       (cnt)
    );

    // Equality (not >=) makes each threshold fire exactly once per stable run.
    assign connectStable = (cnt == CNT_W'(CONNECT_WAIT));
    assign resumeStable  = (cnt == CNT_W'(RESUME_WAIT));

    // State and resume flag registers; reset drops both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= DISCONNECT;
            resumeReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            resumeReg <= resumeNext;
        end
    end

    // Next-state and resume decisions from the debounced line; frozen while disabled.
    always_comb begin
        stateNext  = stateReg;
        resumeNext = resumeReg;
        kLine      = kLineOf(stateReg);
        if (bus.monitor_en) begin
            case (stateReg)
                DISCONNECT: begin
                    resumeNext = 1'b0;
                    if (connectStable && lineState == LINE_FS_J) begin
                        stateNext = FS_CONNECT;
                    end else if (connectStable && lineState == LINE_FS_K) begin
                        stateNext = LS_CONNECT;
                    end
                end
                FS_CONNECT, LS_CONNECT: begin
                    // SE0 (bus reset / detach) wins over anything resume-related.
                    if (connectStable && lineState == LINE_SE0) begin
                        stateNext  = DISCONNECT;
                        resumeNext = 1'b0;
                    end else if (lineState != kLine) begin
                        resumeNext = 1'b0;
                    end else if (resumeStable) begin
                        resumeNext = 1'b1;
                    end
                end
                default: begin
                    stateNext  = DISCONNECT;
                    resumeNext = 1'b0;
                end
            endcase
        end
    end

    assign bus.connect_state   = stateReg;
    assign bus.resume_detected = resumeReg;
    assign bus.line_state      = lineState;

endmodule

// File: tb/tb_usb_slave_line_state_monitor.sv
// Directed bench for the line-state monitor with short thresholds (8 / 16).
module tb_usb_slave_line_state_monitor;
    import usb_line_pkg::*;

    localparam int CW = 8;
    localparam int RW = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        string      tag;
        logic [1:0] conn;
        logic       res;
        logic [1:0] line;
    } exp_t;

    exp_t sbq[$];

    usb_slave_line_state_monitor_if bus ();

    usb_slave_line_state_monitor #(
        .CONNECT_WAIT (CW),
        .RESUME_WAIT  (RW),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one scoreboard entry against the live outputs.
    task automatic compare(input exp_t e);
        checks++;
        assert (bus.connect_state === e.conn) else begin
            errors++;
            $error("FAIL %s connect_state got %b want %b", e.tag, bus.connect_state, e.conn);
        end
        checks++;
        assert (bus.resume_detected === e.res) else begin
            errors++;
            $error("FAIL %s resume_detected got %b want %b", e.tag, bus.resume_detected, e.res);
        end
        checks++;
        assert (bus.line_state === e.line) else begin
            errors++;
            $error("FAIL %s line_state got %b want %b", e.tag, bus.line_state, e.line);
        end
        $display("t=%0t %s rx=%b en=%b conn=%b res=%b line=%b", $time, e.tag, bus.rx_bits,
                 bus.monitor_en, bus.connect_state, bus.resume_detected, bus.line_state);
    endtask

    // Drive one cycle of stimulus, queue its expected result, sample after the edge.
    task automatic step(input logic [1:0] rx, input logic en, input logic [1:0] eConn,
                        input logic eRes, input string tag);
        exp_t e;
        bus.rx_bits    = rx;
        bus.monitor_en = en;
        sbq.push_back('{tag, eConn, eRes, rx});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        compare(e);
    endtask

    // Check outputs at the current time without waiting for a clock edge.
    task automatic checkNow(input logic [1:0] eConn, input logic eRes, input logic [1:0] eLine,
                            input string tag);
        exp_t e;
        sbq.push_back('{tag, eConn, eRes, eLine});
        e = sbq.pop_front();
        compare(e);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.rx_bits    = 2'b10;
        bus.monitor_en = 1'b1;

        // Reset state, then FS attach: change lands on the 9th edge.
        #12;
        checkNow(2'b00, 1'b0, 2'b00, "reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++)
            step(2'b10, 1'b1, (i >= CW + 1) ? 2'b10 : 2'b00, 1'b0, "fs_attach");

        // FS resume: K=01 held 20 cycles, flag from edge 17; back to J clears one edge later.
        for (int i = 1; i <= 20; i++)
            step(2'b01, 1'b1, 2'b10, (i >= RW + 1) ? 1'b1 : 1'b0, "fs_resume");
        for (int i = 1; i <= 4; i++)
            step(2'b10, 1'b1, 2'b10, (i == 1) ? 1'b1 : 1'b0, "fs_resume_end");

        // Short SE0 (7) is only a glitch; a held SE0 disconnects on the 9th edge.
        for (int i = 1; i <= 7; i++)
            step(2'b00, 1'b1, 2'b10, 1'b0, "se0_short");
        for (int i = 1; i <= 2; i++)
            step(2'b10, 1'b1, 2'b10, 1'b0, "se0_short_j");
        for (int i = 1; i <= 12; i++)
            step(2'b00, 1'b1, (i >= CW + 1) ? 2'b00 : 2'b10, 1'b0, "bus_reset");

        // LS attach with a glitch in the first run.
        for (int i = 1; i <= 5; i++)
            step(2'b01, 1'b1, 2'b00, 1'b0, "ls_run1");
        step(2'b00, 1'b1, 2'b00, 1'b0, "ls_glitch");
        for (int i = 1; i <= 12; i++)
            step(2'b01, 1'b1, (i >= CW + 1) ? 2'b01 : 2'b00, 1'b0, "ls_attach");

        // LS resume: K is 10. A 15-sample K is too short; 20 qualifies at edge 17.
        for (int i = 1; i <= 15; i++)
            step(2'b10, 1'b1, 2'b01, 1'b0, "ls_k_short");
        for (int i = 1; i <= 3; i++)
            step(2'b01, 1'b1, 2'b01, 1'b0, "ls_k_short_j");
        for (int i = 1; i <= 20; i++)
            step(2'b10, 1'b1, 2'b01, (i >= RW + 1) ? 1'b1 : 1'b0, "ls_resume");
        for (int i = 1; i <= 3; i++)
            step(2'b01, 1'b1, 2'b01, (i == 1) ? 1'b1 : 1'b0, "ls_resume_end");

        // LS detach, then SE1 noise must never connect.
        for (int i = 1; i <= 9; i++)
            step(2'b00, 1'b1, (i >= CW + 1) ? 2'b00 : 2'b01, 1'b0, "ls_detach");
        for (int i = 1; i <= 20; i++)
            step((i % 2 == 1) ? 2'b10 : 2'b11, 1'b1, 2'b00, 1'b0, "se1_alt");
        for (int i = 1; i <= 12; i++)
            step(2'b11, 1'b1, 2'b00, 1'b0, "se1_held");

        // Disabled: J held 50 cycles changes nothing; re-enable connects 9 edges later.
        for (int i = 1; i <= 50; i++)
            step(2'b10, 1'b0, 2'b00, 1'b0, "disabled");
        for (int i = 1; i <= 12; i++)
            step(2'b10, 1'b1, (i >= CW + 1) ? 2'b10 : 2'b00, 1'b0, "reenable");

        // Async reset during a 12-cycle K run in FS.
        for (int i = 1; i <= 12; i++)
            step(2'b01, 1'b1, 2'b10, 1'b0, "k_run");
        #2;
        rst_n = 1'b0;
        #1;
        checkNow(2'b00, 1'b0, 2'b00, "async_rst_k");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reattach, qualify resume, then async reset must drop the flag without a clock.
        for (int i = 1; i <= 9; i++)
            step(2'b10, 1'b1, (i >= CW + 1) ? 2'b10 : 2'b00, 1'b0, "reattach");
        for (int i = 1; i <= 18; i++)
            step(2'b01, 1'b1, 2'b10, (i >= RW + 1) ? 1'b1 : 1'b0, "resume2");
        #2;
        rst_n = 1'b0;
        #1;
        checkNow(2'b00, 1'b0, 2'b00, "async_rst_resume");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++)
            step(2'b00, 1'b1, 2'b00, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
